// File: rtl/alu_sequencer.sv
// Command sequencer for the 8-bit ALU datapath: queues requests, walks each one through LOAD/EXEC,
// captures the ALU result into a valid/ready response and keeps a running accumulator for chaining.
module alu_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CMD_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_acc,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [2:0]       alu_in_sel,
    output logic [WIDTH-1:0] alu_num1,
    output logic [WIDTH-1:0] alu_num2,
    output logic [6:0]       alu_out_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic [2:0]       state,
    output logic [7:0]       err_count
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int EW = 3 + 1 + 2 * WIDTH;
    localparam logic [PW:0] PTR_ONE  = 1;
    localparam logic [2:0]  OP_MULT  = 3'd6;
    localparam logic [2:0]  OP_CLEAR = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        EXEC  = 3'd2,
        RESP  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     fifo_mem [CMD_DEPTH];
    logic [PW:0]       wr_ptr_q, rd_ptr_q;
    logic              full, empty, push, pop;
    logic [EW-1:0]     head;
    logic [2:0]        head_op;
    logic              head_acc;
    logic [WIDTH-1:0]  head_a, head_b;

    logic [2:0]        cur_op_q, cur_op_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [2:0]        in_sel_q, in_sel_d;
    logic [WIDTH-1:0]  num1_q, num1_d, num2_q, num2_d;
    logic [6:0]        out_sel_q, out_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              mult_err;

    // Output-mux select bit6 is AND (op 0) down to bit0 MULT (op 6); CLEAR selects nothing.
    function automatic logic [6:0] op_onehot(input logic [2:0] op);
        op_onehot = (op == OP_CLEAR) ? 7'b0000000 : (7'b1000000 >> op);
    endfunction

    // Full is judged on the registered pointers only, so a same-cycle pop never opens the gate.
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign head     = fifo_mem[rd_ptr_q[PW-1:0]];
    assign head_op  = head[EW-1 -: 3];
    assign head_acc = head[2*WIDTH];
    assign head_a   = head[2*WIDTH-1 -: WIDTH];
    assign head_b   = head[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {cmd_op, cmd_acc, cmd_a, cmd_b};
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_op_d    = cur_op_q;
        acc_d       = acc_q;
        in_sel_d    = in_sel_q;
        num1_d      = num1_q;
        num2_d      = num2_q;
        out_sel_d   = out_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_count_d = err_count_q;
        mult_err    = alu_overflow && (cur_op_q == OP_MULT);

        case (state_q)
            IDLE: begin
                in_sel_d  = 3'b001;
                num1_d    = '0;
                num2_d    = '0;
                out_sel_d = 7'b0000000;
                if (pop) begin
                    cur_op_d = head_op;
                    in_sel_d = (head_op == OP_CLEAR) ? 3'b001 : 3'b010;
                    num1_d   = head_acc ? acc_q : head_a;
                    num2_d   = head_b;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                out_sel_d = op_onehot(cur_op_q);
                state_d   = EXEC;
            end
            EXEC: begin
                rsp_data_d  = (cur_op_q == OP_CLEAR) ? '0 : alu_result;
                rsp_err_d   = mult_err;
                acc_d       = ((cur_op_q == OP_CLEAR) || mult_err) ? '0 : alu_result;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    in_sel_d    = 3'b001;
                    num1_d      = '0;
                    num2_d      = '0;
                    out_sel_d   = 7'b0000000;
                    state_d     = rsp_err_q ? ERROR : IDLE;
                end
            end
            ERROR: begin
                in_sel_d    = 3'b001;
                err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cur_op_q    <= '0;
            acc_q       <= '0;
            in_sel_q    <= 3'b001;
            num1_q      <= '0;
            num2_q      <= '0;
            out_sel_q   <= 7'b0000000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cur_op_q    <= cur_op_d;
            acc_q       <= acc_d;
            in_sel_q    <= in_sel_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            out_sel_q   <= out_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_ready   = !full;
    assign busy        = (state_q != IDLE) || !empty;
    assign state       = state_q;
    assign alu_in_sel  = in_sel_q;
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = out_sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign err_count   = err_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU closes the loop, expected responses are
// queued at issue time and a negedge monitor compares them whenever a response is presented.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic       cmd_acc;
    logic [7:0] cmd_a, cmd_b;
    logic [2:0] alu_in_sel;
    logic [7:0] alu_num1, alu_num2;
    logic [6:0] alu_out_sel;
    logic [7:0] alu_result;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic [2:0] state;
    logic [7:0] err_count;

    int         checkCount = 0;
    int         failCount  = 0;
    int         errCycles  = 0;
    logic [8:0] expQ[$];
    logic [15:0] prod;

    alu_sequencer #(.WIDTH(8), .CMD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_acc(cmd_acc),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_in_sel(alu_in_sel), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_out_sel(alu_out_sel), .alu_result(alu_result), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .state(state), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the ALU datapath, selected by the one-hot output mux.
    always_comb begin
        prod         = alu_num1 * alu_num2;
        alu_result   = 8'h00;
        alu_overflow = 1'b0;
        case (alu_out_sel)
            7'b1000000: alu_result = alu_num1 & alu_num2;
            7'b0100000: alu_result = alu_num1 | alu_num2;
            7'b0010000: alu_result = ~alu_num1;
            7'b0001000: alu_result = alu_num1 ^ alu_num2;
            7'b0000100: alu_result = alu_num1 + alu_num2;
            7'b0000010: alu_result = alu_num1 - alu_num2;
            7'b0000001: begin
                alu_result   = prod[7:0];
                alu_overflow = |prod[15:8];
            end
            default: alu_result = 8'h00;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Offers one command, records its expected response, and returns 1ns after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic useAcc, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] expData, input logic expErr);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_acc   = useAcc;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        expQ.push_back({expErr, expData});
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: pops on handshake, and checks the held value while stalled.
    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected response", 32'({rsp_err, rsp_data}), 32'h1ff);
            end else if (rsp_ready) begin
                checkOutput("response", 32'({rsp_err, rsp_data}), 32'(expQ.pop_front()));
            end else begin
                checkOutput("stalled response", 32'({rsp_err, rsp_data}), 32'(expQ[0]));
            end
        end
        if (rst && state == 3'd4) errCycles++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_acc   = 1'b0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", 32'(state), 32'd0);
        checkOutput("reset in_sel", 32'(alu_in_sel), 32'b001);
        checkOutput("reset out_sel", 32'(alu_out_sel), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("reset err_count", 32'(err_count), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single ADD with cycle-exact latency checks.
        stepCycle();
        rsp_ready = 1'b1;
        applyStimulus(3'd4, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0);
        stepCycle();
        checkOutput("add LOAD state", 32'(state), 32'd1);
        checkOutput("add LOAD in_sel", 32'(alu_in_sel), 32'b010);
        checkOutput("add LOAD num1", 32'(alu_num1), 32'h0F);
        checkOutput("add LOAD num2", 32'(alu_num2), 32'h01);
        stepCycle();
        checkOutput("add EXEC state", 32'(state), 32'd2);
        checkOutput("add EXEC out_sel", 32'(alu_out_sel), 32'b0000100);
        stepCycle();
        checkOutput("add rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("add rsp_data", 32'(rsp_data), 32'h10);
        waitIdle("add idle timeout", 50);

        // Accumulator chaining and wrap-around subtraction.
        applyStimulus(3'd4, 1'b0, 8'h05, 8'h03, 8'h08, 1'b0);
        applyStimulus(3'd5, 1'b1, 8'hAA, 8'h02, 8'h06, 1'b0);
        applyStimulus(3'd5, 1'b0, 8'h00, 8'h01, 8'hFF, 1'b0);
        waitIdle("chain idle timeout", 100);

        // Multiplier overflow: error response, one ERROR cycle, accumulator cleared.
        errCycles = 0;
        applyStimulus(3'd6, 1'b0, 8'h20, 8'h10, 8'h00, 1'b1);
        applyStimulus(3'd4, 1'b1, 8'h77, 8'h01, 8'h01, 1'b0);
        waitIdle("mult idle timeout", 100);
        checkOutput("mult err_count", 32'(err_count), 32'd1);
        checkOutput("mult error cycles", 32'(errCycles), 32'd1);

        // Back-pressure: four queued plus one in flight fills the FIFO.
        stepCycle();
        rsp_ready = 1'b0;
        applyStimulus(3'd3, 1'b0, 8'hA5, 8'h0F, 8'hAA, 1'b0);
        applyStimulus(3'd0, 1'b0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        applyStimulus(3'd1, 1'b0, 8'h0F, 8'h30, 8'h3F, 1'b0);
        applyStimulus(3'd2, 1'b0, 8'h55, 8'h00, 8'hAA, 1'b0);
        applyStimulus(3'd4, 1'b0, 8'hFF, 8'h02, 8'h01, 1'b0);
        checkOutput("backpressure cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (10) stepCycle();
        checkOutput("backpressure state", 32'(state), 32'd3);
        checkOutput("backpressure busy", 32'(busy), 32'd1);
        rsp_ready = 1'b1;
        waitIdle("backpressure idle timeout", 100);

        // CLEAR after a non-zero accumulator.
        applyStimulus(3'd4, 1'b0, 8'h40, 8'h02, 8'h42, 1'b0);
        waitIdle("preclear idle timeout", 50);
        applyStimulus(3'd7, 1'b0, 8'h12, 8'h34, 8'h00, 1'b0);
        stepCycle();
        checkOutput("clear LOAD state", 32'(state), 32'd1);
        checkOutput("clear LOAD in_sel", 32'(alu_in_sel), 32'b001);
        stepCycle();
        checkOutput("clear EXEC out_sel", 32'(alu_out_sel), 32'd0);
        applyStimulus(3'd4, 1'b1, 8'h99, 8'h01, 8'h01, 1'b0);
        waitIdle("clear idle timeout", 50);

        // Reset while a command executes and two more are queued.
        applyStimulus(3'd4, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0);
        applyStimulus(3'd4, 1'b0, 8'h02, 8'h02, 8'h04, 1'b0);
        applyStimulus(3'd4, 1'b0, 8'h03, 8'h03, 8'h06, 1'b0);
        checkOutput("pre-reset state", 32'(state), 32'd2);
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midreset state", 32'(state), 32'd0);
        checkOutput("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midreset in_sel", 32'(alu_in_sel), 32'b001);
        checkOutput("midreset cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midreset err_count", 32'(err_count), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stepCycle();
        checkOutput("post-reset busy", 32'(busy), 32'd0);

        // Overflow counter saturation.
        for (int i = 0; i < 256; i++) begin
            applyStimulus(3'd6, 1'b0, 8'hFF, 8'h02, 8'hFE, 1'b1);
            if (i == 9) begin
                waitIdle("sat10 idle timeout", 100);
                checkOutput("err_count after 10", 32'(err_count), 32'd10);
            end
        end
        waitIdle("saturation idle timeout", 200);
        checkOutput("err_count saturated", 32'(err_count), 32'd255);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
